// File: rtl/player_sprite_drawer.sv
// Player sprite drawer: erases the old SIZE x SIZE square and plots the new one
// into the 160x120 framebuffer port, one pixel per clock, with edge clipping.
//
// state | meaning
// IDLE  | waiting for a stable, changed position; plot held low
// ERASE | scanning the square at drawn_q with the background colour
// DRAW  | scanning the square at target_q with the player colour
module player_sprite_drawer #(
  parameter int          SIZE          = 4,
  parameter logic [2:0]  PLAYER_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter int          X_MAX         = 159,
  parameter int          Y_MAX         = 119
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] playerx,
  input  logic [6:0] playery,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW} state_t;

  localparam logic [2:0] LAST  = 3'(SIZE - 1);
  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  state_t      state_q, state_d;
  logic [14:0] pos_q;
  logic [14:0] drawn_q, drawn_d;
  logic [14:0] target_q, target_d;
  logic        first_q, first_d;
  logic [2:0]  cx_q, cx_d;
  logic [2:0]  cy_q, cy_d;

  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;

  logic [14:0] cur;
  logic [14:0] base;
  logic [8:0]  x_sum;
  logic [7:0]  y_sum;
  logic        stable;
  logic        in_range;
  logic        last_px;

  assign cur     = {playery, playerx};
  assign stable  = (cur == pos_q);
  assign base    = (state_q == ERASE) ? drawn_q : target_q;
  // Sums are one bit wider than the coordinates so x=255+3 clips instead of aliasing.
  assign x_sum    = {1'b0, base[7:0]} + {6'd0, cx_q};
  assign y_sum    = {1'b0, base[14:8]} + {5'd0, cy_q};
  assign in_range = (x_sum <= X_LIM) && (y_sum <= Y_LIM);
  assign last_px  = (cx_q == LAST) && (cy_q == LAST);

  always_comb begin
    state_d  = state_q;
    drawn_d  = drawn_q;
    target_d = target_q;
    first_d  = first_q;
    cx_d     = cx_q;
    cy_d     = cy_q;

    if (state_q != IDLE) begin
      if (cx_q == LAST) begin
        cx_d = 3'd0;
        cy_d = cy_q + 3'd1;
      end else begin
        cx_d = cx_q + 3'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (stable && (first_q || (cur != drawn_q))) begin
          target_d = cur;
          cx_d     = 3'd0;
          cy_d     = 3'd0;
          state_d  = first_q ? DRAW : ERASE;
        end
      end
      ERASE: begin
        if (last_px) begin
          cx_d    = 3'd0;
          cy_d    = 3'd0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (last_px) begin
          cx_d    = 3'd0;
          cy_d    = 3'd0;
          drawn_d = target_q;
          first_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    if (state_q != IDLE) begin
      x_d      = x_sum[7:0];
      y_d      = y_sum[6:0];
      colour_d = (state_q == ERASE) ? BG_COLOUR : PLAYER_COLOUR;
      plot_d   = in_range;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      drawn_q  <= '0;
      target_q <= '0;
      first_q  <= 1'b1;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= cur;
      drawn_q  <= drawn_d;
      target_q <= target_d;
      first_q  <= first_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: doc/player_sprite_drawer.md
# player_sprite_drawer

Downstream stage of the switch-driven player movement logic. Consumes the player position (`playerx` 8-bit, `playery` 7-bit) and drives the 160x120 VGA framebuffer adapter's pixel-write port. When the position changes, it erases the old SIZE x SIZE square with the background colour, then plots the square at the new position, one pixel per clock. Off-screen pixels are clipped.

## Interface
- `SIZE`, 4: side of the square sprite in pixels (1..8).
- `PLAYER_COLOUR`, 3'b111: colour of the drawn square.
- `BG_COLOUR`, 3'b000: colour used for erase.
- `X_MAX`, 159: last visible column.
- `Y_MAX`, 119: last visible row.

Ports:
- `CLOCK_50`  in  1  system clock; all logic on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `playerx`  in  8  requested sprite top-left column.
- `playery`  in  7  requested sprite top-left row.
- `x`  out  8  framebuffer write column.
- `y`  out  7  framebuffer write row.
- `colour`  out  3  framebuffer write colour.
- `plot`  out  1  write strobe; one pixel is written per cycle while high.
- `busy`  out  1  high while an erase/draw sequence is in progress (state != IDLE).

## Operation
- Registers:
  - `pos_q` holds the previous-cycle sample of {playery, playerx}.
  - `drawn` holds the position currently on screen.
  - `target` holds the position being drawn.
  - `first` is a flag set by reset.
  - `cx` and `cy` are 3-bit pixel counters.
- Reset state:
  - `state` = IDLE.
  - `pos_q`, `drawn`, `target`, `cx`, `cy` all 0.
  - `first` = 1.
  - Outputs `x` = 0, `y` = 0, `colour` = 0, `plot` = 0, `busy` = 0.
- `pos_q` loads every cycle in every state.
- Stability filter: a position is accepted only when the input equals `pos_q`, i.e. it has been identical for two consecutive samples. Single-cycle glitches never start a sequence.
- IDLE transitions:
  - Input is stable and (`first` = 1): load `target`, clear counters, go to DRAW.
  - Input is stable, `first` = 0, and input != `drawn`: load `target`, clear counters, go to ERASE.
  - Otherwise stay in IDLE.
- ERASE:
  - Pixel = (`drawn.x` + `cx`, `drawn.y` + `cy`), colour = `BG_COLOUR`.
  - Scan order is `cx` fastest: `cx` wraps SIZE-1 -> 0 and increments `cy`.
  - After pixel (SIZE-1, SIZE-1): clear counters, go to DRAW.
- DRAW:
  - Same scan over `target`, colour = `PLAYER_COLOUR`.
  - After the last pixel: `drawn` <= `target`, `first` <= 0, go to IDLE.
- Input changes during ERASE or DRAW are ignored. They are re-evaluated in IDLE; only the final stable value is drawn.
- Arithmetic and clipping:
  - Sums are computed 9 bits wide for x and 8 bits wide for y.
  - A pixel is in range when x sum <= `X_MAX` and y sum <= `Y_MAX`.
  - Out-of-range pixels: `plot` = 0 for that slot, counters still advance, sequence length unchanged.
  - `x`/`y` carry the truncated low bits of the sums.
- `drawn` stores the full unclipped position, so a later erase clips identically.

## Timing
- `x`, `y`, `colour`, `plot` are registered: the pixel for counter value (`cx`, `cy`) in state S appears on the outputs one cycle after the FSM is in S with those counters.
- In IDLE, the registered `plot` is 0.
- `busy` is combinational from state, so `plot` lags `busy` by exactly one cycle.
- Latency: input changes at edge E0 -> accepted at E2 -> first pixel on outputs after E3.
- Sequence length: ERASE is exactly SIZE² cycles, DRAW is exactly SIZE² cycles, with no gap between them.
- Back-to-back moves: at least one IDLE cycle separates sequences.
- Reset mid-sequence: all outputs clear asynchronously and the state returns to IDLE. The next accepted position is drawn with no erase; stale pixels are not the block's responsibility.
- Coordinate wrap: `playerx` = 255 yields x sums 255..258, all clipped; no aliasing to column 0.

## Test plan
- Reset release with input held at (10,20):
  - `plot` first high after the 3rd rising edge.
  - Exactly 16 consecutive plots, x 10..13, y 20..23, row-major, `colour` = 7.
  - No erase pixels.
- From drawn (10,20), input steps to (11,20):
  - 16 erase plots (colour 0) over x 10..13 / y 20..23, then 16 draw plots (colour 7) over x 11..14 / y 20..23.
  - `busy` high for 32 cycles, then `drawn` = (11,20).
- Draw at (158,118) from reset:
  - 16-cycle DRAW phase, only 4 plots: (158,118), (159,118), (158,119), (159,119).
  - `busy` still high 16 cycles.
- Input pulses to (50,50) for one cycle and returns to (11,20): no sequence, `busy` stays 0.
- Input moves to (20,20) mid-DRAW, then to (30,30) before IDLE:
  - The current sequence completes unchanged.
  - Next sequence erases the just-drawn square and draws at (30,30).
- `resetn` asserted on the 5th ERASE cycle:
  - Outputs 0 immediately.
  - After release, a DRAW-only sequence at the current stable input.
